rf_wb_scheduler: RTL and testbench

Write-back scheduler for the single register-file write port. It arbitrates each cycle between the in-order pipeline write-back result (ALU, LUI/AUIPC, JAL/JALR link value) and out-of-order load returns from the multi-cycle memory unit. Load returns are held in a small FIFO and drained into idle write-port slots. Its only lever on the pipeline is a stall request.

---
 rtl/rf_wb_scheduler.sv | 130 +++++++++++++
 tb/tb_rf_wb_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: pipeline write-back has priority, load returns queue in a FIFO.
// Optional macro RF_WB_STARVE_EN forces a one-cycle pipe stall when the FIFO head is denied too long.
module rf_wb_scheduler #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic        pipe_regwrite,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        ld_valid,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0] kill_q, kill_d;
    logic [4:0]  ent_rd_q   [DEPTH];
    logic [31:0] ent_data_q [DEPTH];
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_rd_q, rf_rd_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        full, nonempty, starve_hit, pipe_req, push, store, pop;

    assign full       = (count_q == FULL_C);
    assign nonempty   = (count_q != '0);
    assign pipe_stall = full | starve_hit;
    assign ld_ready   = !full;
    assign pipe_req   = pipe_valid && pipe_regwrite && (pipe_rd != 5'd0) && !pipe_stall;
    assign push       = ld_valid && ld_ready;
    assign store      = push && (ld_rd != 5'd0);
    assign pop        = !pipe_req && nonempty;

`ifdef RF_WB_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_q, starve_d;

    assign starve_hit = (starve_q == LIMIT_C);

    always_comb begin
        starve_d = starve_q;
        if (pop || !nonempty) starve_d = '0;
        else if (starve_q != LIMIT_C) starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        kill_d     = kill_q;
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_req) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = pipe_rd;
            rf_wdata_d = pipe_data;
            // A younger pipe write to the same rd makes any buffered load result stale.
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_rd_q[i] == pipe_rd) kill_d[i] = 1'b1;
            end
        end else if (pop) begin
            rf_we_d    = !kill_q[head_q];
            rf_rd_d    = ent_rd_q[head_q];
            rf_wdata_d = ent_data_q[head_q];
            head_d     = (head_q == LAST_C) ? '0 : head_q + 1'b1;
        end
        if (store) begin
            kill_d[tail_q] = pipe_req && (ld_rd == pipe_rd);
            tail_d         = (tail_q == LAST_C) ? '0 : tail_q + 1'b1;
        end
        case ({store, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            kill_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= 32'd0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            kill_q     <= kill_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            ent_rd_q[tail_q]   <= ld_rd;
            ent_data_q[tail_q] <= ld_data;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Scoreboard bench for rf_wb_scheduler: a queue-based reference model predicts writes and stalls.
module tb_rf_wb_scheduler;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
`ifdef RF_WB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, pipe_regwrite;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;

    rf_wb_scheduler #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_valid(pipe_valid), .pipe_regwrite(pipe_regwrite), .pipe_rd(pipe_rd),
        .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] rd; logic [31:0] data; } wr_t;
    typedef struct packed { logic [4:0] rd; logic [31:0] data; bit kill; } ent_t;

    wr_t   expq[$];
    ent_t  mq[$];
    int    m_starve = 0;
    bit    m_stall, m_ld_acc;
    int    stall_cycles = 0;
    logic [31:0] dut_rf [32];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every DUT write must match the oldest predicted write.
    always @(negedge clk) begin
        wr_t e;
        if (rf_we === 1'b1) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%08h, expected no write at %0t",
                         rf_rd, rf_wdata, $time);
            end else begin
                e = expq.pop_front();
                chk("wr_rd", 32'(rf_rd), 32'(e.rd));
                chk("wr_data", rf_wdata, e.data);
            end
            dut_rf[rf_rd] = rf_wdata;
        end
    end

    task automatic model_cycle();
        bit   mfull, mhit, preq, popd, had;
        ent_t e;
        mfull = (mq.size() == DEPTH);
        mhit  = STARVE_EN && (m_starve >= STARVE_LIMIT);
        chk("pipe_stall", 32'(pipe_stall), 32'(mfull || mhit));
        chk("ld_ready", 32'(ld_ready), 32'(!mfull));
        if (pipe_stall === 1'b1) stall_cycles++;
        m_stall  = mfull || mhit;
        m_ld_acc = ld_valid && !mfull;
        had  = (mq.size() > 0);
        preq = pipe_valid && pipe_regwrite && (pipe_rd != 5'd0) && !m_stall;
        popd = 1'b0;
        if (preq) begin
            expq.push_back('{rd: pipe_rd, data: pipe_data});
            foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].kill = 1'b1;
        end else if (had) begin
            e    = mq.pop_front();
            popd = 1'b1;
            if (!e.kill) expq.push_back('{rd: e.rd, data: e.data});
        end
        if (m_ld_acc && ld_rd != 5'd0)
            mq.push_back('{rd: ld_rd, data: ld_data, kill: preq && (ld_rd == pipe_rd)});
        if (had && !popd) m_starve++;
        else              m_starve = 0;
    endtask

    task automatic step(input bit pv, input bit prw, input logic [4:0] prd, input logic [31:0] pd,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        pipe_valid = pv; pipe_regwrite = prw; pipe_rd = prd; pipe_data = pd;
        ld_valid = lv; ld_rd = lrd; ld_data = ld;
        #1;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        pipe_valid = 0; pipe_regwrite = 0; pipe_rd = 0; pipe_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        rst = 1'b1;
        mq.delete();
        m_starve = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pv, prw, lv, hold_p, hold_l;
        logic [4:0]  prd, lrd;
        logic [31:0] pd, ld;
        int          j;

        foreach (dut_rf[i]) dut_rf[i] = 32'd0;
        do_reset();

        // Basic pipe write, then load on an idle pipe.
        step(1, 1, 5'd5, 32'h0000_1000, 0, 5'd0, 32'd0);
        idle(1);
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'hDEAD_BEEF);
        idle(3);

        // Continuous pipe writes while two loads fill the FIFO.
        j = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 5'(1 + j), 32'h100 + 32'(j), k < 2, 5'(10 + k), 32'hA000 + 32'(k));
            if (!m_stall) j++;
        end
        idle(3);

        // WAW kill: buffered load to x3 overtaken by a pipe write to x3.
        step(1, 1, 5'd9, 32'h99, 1, 5'd3, 32'hAA);
        step(1, 1, 5'd3, 32'h11, 0, 5'd0, 32'd0);
        idle(3);
        chk("x3_final", dut_rf[3], 32'h11);
        step(1, 1, 5'd4, 32'h44, 1, 5'd4, 32'h55);
        idle(3);
        chk("x4_final", dut_rf[4], 32'h44);

        // x0 destinations never write.
        step(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'h1234);
        step(1, 1, 5'd0, 32'h5678, 0, 5'd0, 32'd0);
        idle(3);

        // Starvation: one load behind continuous pipe writes.
        stall_cycles = 0;
        j = 0;
        for (int k = 0; k < 12; k++) begin
            step(1, 1, 5'(12 + (j % 6)), 32'h300 + 32'(j), k == 0, 5'd20, 32'hBEEF_0020);
            if (!m_stall) j++;
        end
        chk("starve_stall_cycles", 32'(stall_cycles), STARVE_EN ? 32'd1 : 32'd0);
        idle(3);

        // Reset with loads buffered discards them.
        step(1, 1, 5'd1, 32'h501, 1, 5'd21, 32'h521);
        step(1, 1, 5'd2, 32'h502, 1, 5'd22, 32'h522);
        do_reset();
        idle(4);

        // Randomized traffic; the pipe and memory unit re-present refused items.
        hold_p = 0; hold_l = 0;
        pv = 0; prw = 0; prd = 0; pd = 0; lv = 0; lrd = 0; ld = 0;
        for (int k = 0; k < 2000; k++) begin
            if (!hold_p) begin
                pv  = ($urandom_range(0, 9) < 7);
                prw = ($urandom_range(0, 9) < 8);
                prd = 5'($urandom_range(0, 7));
                pd  = $urandom;
            end
            if (!hold_l) begin
                lv  = ($urandom_range(0, 9) < 4);
                lrd = 5'($urandom_range(0, 7));
                ld  = $urandom;
            end
            step(pv, prw, prd, pd, lv, lrd, ld);
            hold_p = pv && m_stall;
            hold_l = lv && !m_ld_acc;
        end
        idle(6);
        chk("expq_empty", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
